// File: rtl/wb_pkg.sv
// Write-back stage shared constants: source-select codes and load funct3 codes.
package wb_pkg;

  // Write-back source select
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_CSR = 2'b11;

  // Load funct3 encodings
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment and extension: picks the addressed byte/halfword out of the
// raw load word and sign- or zero-extends it to XLEN. Purely combinational.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Extract the addressed byte and halfword; addr_lo[0] is ignored for halfwords
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'd0:    byte_s = mem_data[7:0];
      2'd1:    byte_s = mem_data[15:8];
      2'd2:    byte_s = mem_data[23:16];
      2'd3:    byte_s = mem_data[31:24];
      default: byte_s = mem_data[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = mem_data[31:16];
    end else begin
      half_s = mem_data[15:0];
    end
  end

  // Extend to full width according to the load type; unknown codes pass the word through
  always_comb begin
    result = mem_data;
    case (funct3)
      LOAD_LB:  result = {{(XLEN-8){byte_s[7]}}, byte_s};
      LOAD_LBU: result = {{(XLEN-8){1'b0}}, byte_s};
      LOAD_LH:  result = {{(XLEN-16){half_s[15]}}, half_s};
      LOAD_LHU: result = {{(XLEN-16){1'b0}}, half_s};
      LOAD_LW:  result = mem_data;
      default:  result = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register: selects the write-back source, drives the
// register-file write port and counts retired instructions.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_rf_we,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [1:0]            in_wb_sel,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_mem_data,
  input  logic [2:0]            in_load_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [XLEN-1:0]       in_pc_plus4,
  input  logic [XLEN-1:0]       in_csr_rdata,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  wb_valid,
  output logic [CNT_W-1:0]      instret
);

  logic [XLEN-1:0]       load_data_s;
  logic [XLEN-1:0]       wb_data_s;
  logic                  rf_we_r;
  logic [REG_ADDR_W-1:0] rf_waddr_r;
  logic [XLEN-1:0]       rf_wdata_r;
  logic                  wb_valid_r;
  logic [CNT_W-1:0]      instret_r;

  load_align #(.XLEN(XLEN)) u_load_align (
    .mem_data (in_mem_data),
    .funct3   (in_load_funct3),
    .addr_lo  (in_addr_lo),
    .result   (load_data_s)
  );

  // Write-back source mux
  always_comb begin
    wb_data_s = in_alu_result;
    case (in_wb_sel)
      WB_SEL_ALU: wb_data_s = in_alu_result;
      WB_SEL_MEM: wb_data_s = load_data_s;
      WB_SEL_PC4: wb_data_s = in_pc_plus4;
      WB_SEL_CSR: wb_data_s = in_csr_rdata;
      default:    wb_data_s = in_alu_result;
    endcase
  end

  // Pipeline register and retire counter; flush beats stall beats capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REG_ADDR_W{1'b0}};
      rf_wdata_r <= {XLEN{1'b0}};
      wb_valid_r <= 1'b0;
      instret_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REG_ADDR_W{1'b0}};
      rf_wdata_r <= {XLEN{1'b0}};
      wb_valid_r <= 1'b0;
    end else if (stall) begin
      // Held instruction already wrote once; suppress a repeat write
      rf_we_r <= 1'b0;
    end else begin
      wb_valid_r <= in_valid;
      rf_we_r    <= in_valid & in_rf_we & (in_rd != {REG_ADDR_W{1'b0}});
      rf_waddr_r <= in_rd;
      rf_wdata_r <= wb_data_s;
      if (in_valid) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign wb_valid = wb_valid_r;
  assign instret  = instret_r;

endmodule
